// File: rtl/detection_event_tracker_pkg.sv
// Shared FSM state encodings and a constant-width helper for the event tracker.
package detection_event_tracker_pkg;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StArming   = 2'd1,
      StActive   = 2'd2,
      StCooldown = 2'd3
   } det_state_e;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/detection_event_tracker_fifo.sv
// Show-ahead synchronous FIFO holding event timestamps; a push to a full FIFO
// lands only when a pop frees the head slot in the same cycle.
module detection_event_tracker_fifo
   import detection_event_tracker_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] head_o
);

   localparam int unsigned AddrW = clog2(DEPTH);
   localparam int unsigned PtrW  = AddrW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q;
   logic [PtrW-1:0]  rd_ptr_q;
   logic             pop_en;
   logic             push_en;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                    (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
   assign head_o  = mem_q[rd_ptr_q[AddrW-1:0]];

   assign pop_en  = pop_i && !empty_o;
   // When full, the write slot is the head being popped this cycle.
   assign push_en = push_i && (!full_o || pop_en);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (push_en) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= push_data_i;
            wr_ptr_q                   <= wr_ptr_q + PtrW'(1);
         end
         if (pop_en) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
      end
   end

endmodule

// File: rtl/detection_event_tracker.sv
// Debounces the per-pixel detection flag into confirmed object events, holds an alert,
// counts events and queues a timestamp per event for a valid/ready consumer.
module detection_event_tracker
   import detection_event_tracker_pkg::*;
#(
   parameter int unsigned CONFIRM_N  = 3,
   parameter int unsigned COOLDOWN   = 8,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TS_W       = 16,
   parameter int unsigned CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pix_valid_i,
   input  logic             det_in_i,
   input  logic             evt_ready_i,
   output logic             evt_valid_o,
   output logic [TS_W-1:0]  evt_data_o,
   output logic             alert_o,
   output logic [CNT_W-1:0] evt_count_o,
   output logic             overflow_o
);

   localparam int unsigned ArmW  = (clog2(CONFIRM_N) > 0) ? clog2(CONFIRM_N) : 1;
   localparam int unsigned CoolW = (clog2(COOLDOWN) > 0) ? clog2(COOLDOWN) : 1;

   det_state_e       state_q;
   logic [ArmW-1:0]  arm_cnt_q;
   logic [CoolW-1:0] cool_cnt_q;
   logic [TS_W-1:0]  ts_q;
   logic [CNT_W-1:0] evt_count_q;
   logic [CNT_W-1:0] evt_count_d;
   logic             overflow_q;
   logic             overflow_d;
   logic             alert_q;
   logic             hit;
   logic             miss;
   logic             confirm;
   logic             fifo_full;
   logic             fifo_empty;

   assign hit  = pix_valid_i && det_in_i;
   assign miss = pix_valid_i && !det_in_i;

   always_comb begin
      confirm = 1'b0;
      if (hit) begin
         if (state_q == StIdle && CONFIRM_N == 1) begin
            confirm = 1'b1;
         end
         if (state_q == StArming && arm_cnt_q == ArmW'(CONFIRM_N - 1)) begin
            confirm = 1'b1;
         end
      end
      evt_count_d = (confirm && evt_count_q != '1) ? evt_count_q + CNT_W'(1) : evt_count_q;
      // A full FIFO only loses the event if the consumer is not popping this cycle.
      overflow_d  = overflow_q || (confirm && fifo_full && !evt_ready_i);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ts_q        <= '0;
         evt_count_q <= '0;
         overflow_q  <= 1'b0;
      end else begin
         ts_q        <= ts_q + TS_W'(1);
         evt_count_q <= evt_count_d;
         overflow_q  <= overflow_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         arm_cnt_q  <= '0;
         cool_cnt_q <= '0;
         alert_q    <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (hit) begin
                  if (CONFIRM_N == 1) begin
                     state_q <= StActive;
                     alert_q <= 1'b1;
                  end else begin
                     state_q   <= StArming;
                     arm_cnt_q <= ArmW'(1);
                  end
               end
            end
            StArming: begin
               if (confirm) begin
                  state_q   <= StActive;
                  arm_cnt_q <= '0;
                  alert_q   <= 1'b1;
               end else if (hit) begin
                  arm_cnt_q <= arm_cnt_q + ArmW'(1);
               end else if (miss) begin
                  state_q   <= StIdle;
                  arm_cnt_q <= '0;
               end
            end
            StActive: begin
               if (miss) begin
                  state_q    <= StCooldown;
                  cool_cnt_q <= '0;
               end
            end
            StCooldown: begin
               // Re-detection here is the same object, so no new event.
               if (hit) begin
                  state_q    <= StActive;
                  cool_cnt_q <= '0;
               end else if (cool_cnt_q == CoolW'(COOLDOWN - 1)) begin
                  state_q    <= StIdle;
                  cool_cnt_q <= '0;
                  alert_q    <= 1'b0;
               end else begin
                  cool_cnt_q <= cool_cnt_q + CoolW'(1);
               end
            end
            default: begin
               state_q <= StIdle;
               alert_q <= 1'b0;
            end
         endcase
      end
   end

   detection_event_tracker_fifo #(
      .WIDTH (TS_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (confirm),
      .push_data_i (ts_q),
      .pop_i       (evt_ready_i),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .head_o      (evt_data_o)
   );

   assign evt_valid_o = !fifo_empty;
   assign alert_o     = alert_q;
   assign evt_count_o = evt_count_q;
   assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_detection_event_tracker.sv
// Directed bench for detection_event_tracker with default parameters.
module tb_detection_event_tracker;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pix_valid = 1'b0;
   logic        det_in = 1'b0;
   logic        evt_ready = 1'b0;
   logic        evt_valid;
   logic [15:0] evt_data;
   logic        alert;
   logic [7:0]  evt_count;
   logic        overflow;

   int          checks = 0;
   int          failures = 0;
   logic [15:0] ts_model;
   logic [15:0] last_ts;

   detection_event_tracker dut (
      .clk         (clk),
      .rst         (rst),
      .pix_valid_i (pix_valid),
      .det_in_i    (det_in),
      .evt_ready_i (evt_ready),
      .evt_valid_o (evt_valid),
      .evt_data_o  (evt_data),
      .alert_o     (alert),
      .evt_count_o (evt_count),
      .overflow_o  (overflow)
   );

   always #5 clk = ~clk;

   // Reference timestamp: cycles since reset release.
   always @(posedge clk or posedge rst) begin
      if (rst) ts_model <= 16'd0;
      else     ts_model <= ts_model + 16'd1;
   end

   task automatic step(input logic p, input logic d);
      pix_valid = p;
      det_in    = d;
      last_ts   = ts_model;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      pix_valid = 1'b0;
      det_in = 1'b0;
      evt_ready = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic confirm_obj(output logic [15:0] ts);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      ts = last_ts;
   endtask

   task automatic release_obj();
      for (int i = 0; i < 9; i++) step(1'b1, 1'b0);
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({alert, evt_valid, overflow} !== 3'b000) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=000", {alert, evt_valid, overflow});
      end
      checks++;
      if (evt_count !== 8'd0 || evt_data !== 16'd0) begin
         failures++;
         $display("FAIL reset_values count=%h data=%h exp=00/0000", evt_count, evt_data);
      end
   endtask

   task automatic test_confirm();
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      checks++;
      if (alert !== 1'b0) begin
         failures++;
         $display("FAIL confirm_early_alert got=%b exp=0", alert);
      end
      step(1'b1, 1'b1);
      checks++;
      if (alert !== 1'b1 || evt_valid !== 1'b1) begin
         failures++;
         $display("FAIL confirm_alert_valid got=%b%b exp=11", alert, evt_valid);
      end
      checks++;
      if (evt_data !== 16'h000C || evt_count !== 8'd1) begin
         failures++;
         $display("FAIL confirm_data data=%h count=%0d exp=000c/1", evt_data, evt_count);
      end
   endtask

   task automatic test_cooldown();
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      checks++;
      if (alert !== 1'b1 || evt_count !== 8'd1) begin
         failures++;
         $display("FAIL cool_redetect alert=%b count=%0d exp=1/1", alert, evt_count);
      end
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
      checks++;
      if (alert !== 1'b1) begin
         failures++;
         $display("FAIL cool_hold got=%b exp=1", alert);
      end
      step(1'b1, 1'b0);
      checks++;
      if (alert !== 1'b0) begin
         failures++;
         $display("FAIL cool_drop got=%b exp=0", alert);
      end
      step(1'b1, 1'b1);
      checks++;
      if (alert !== 1'b0 || evt_count !== 8'd1) begin
         failures++;
         $display("FAIL cool_idle alert=%b count=%0d exp=0/1", alert, evt_count);
      end
   endtask

   task automatic test_short_burst();
      do_reset();
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      checks++;
      if (alert !== 1'b0 || evt_valid !== 1'b0 || evt_count !== 8'd0) begin
         failures++;
         $display("FAIL short_burst alert=%b valid=%b count=%0d exp=0/0/0",
                  alert, evt_valid, evt_count);
      end
   endtask

   task automatic test_overflow();
      logic [15:0] exp_ts [4];
      logic [15:0] t;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         confirm_obj(t);
         if (i < 4) exp_ts[i] = t;
         release_obj();
         if (i == 3) begin
            checks++;
            if (overflow !== 1'b0) begin
               failures++;
               $display("FAIL ovf_early got=%b exp=0", overflow);
            end
         end
      end
      checks++;
      if (evt_count !== 8'd5 || overflow !== 1'b1) begin
         failures++;
         $display("FAIL ovf_state count=%0d ovf=%b exp=5/1", evt_count, overflow);
      end
      pix_valid = 1'b0;
      evt_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (evt_valid !== 1'b1 || evt_data !== exp_ts[i]) begin
            failures++;
            $display("FAIL ovf_pop%0d valid=%b data=%h exp=1/%h", i, evt_valid, evt_data,
                     exp_ts[i]);
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if (evt_valid !== 1'b0) begin
         failures++;
         $display("FAIL ovf_drain got=%b exp=0", evt_valid);
      end
      evt_ready = 1'b0;
   endtask

   task automatic test_sparse_valid();
      do_reset();
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      checks++;
      if (alert !== 1'b0) begin
         failures++;
         $display("FAIL sparse_two got=%b exp=0", alert);
      end
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      checks++;
      if (alert !== 1'b1 || evt_count !== 8'd1) begin
         failures++;
         $display("FAIL sparse_third alert=%b count=%0d exp=1/1", alert, evt_count);
      end
      do_reset();
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      checks++;
      if (alert !== 1'b0) begin
         failures++;
         $display("FAIL rearm_early got=%b exp=0", alert);
      end
      step(1'b1, 1'b1);
      checks++;
      if (alert !== 1'b1) begin
         failures++;
         $display("FAIL rearm_confirm got=%b exp=1", alert);
      end
   endtask

   task automatic test_async_reset();
      logic [15:0] t;
      do_reset();
      confirm_obj(t);
      release_obj();
      confirm_obj(t);
      checks++;
      if (alert !== 1'b1 || evt_valid !== 1'b1 || evt_count !== 8'd2) begin
         failures++;
         $display("FAIL pre_rst alert=%b valid=%b count=%0d exp=1/1/2",
                  alert, evt_valid, evt_count);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({alert, evt_valid, overflow} !== 3'b000 || evt_count !== 8'd0 ||
          evt_data !== 16'd0) begin
         failures++;
         $display("FAIL async_rst flags=%b count=%0d data=%h exp=000/0/0000",
                  {alert, evt_valid, overflow}, evt_count, evt_data);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_saturate();
      logic [15:0] t;
      do_reset();
      for (int i = 0; i < 255; i++) begin
         confirm_obj(t);
         release_obj();
      end
      checks++;
      if (evt_count !== 8'hFF || overflow !== 1'b1) begin
         failures++;
         $display("FAIL sat_255 count=%h ovf=%b exp=ff/1", evt_count, overflow);
      end
      confirm_obj(t);
      release_obj();
      checks++;
      if (evt_count !== 8'hFF) begin
         failures++;
         $display("FAIL sat_256 got=%h exp=ff", evt_count);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (overflow !== 1'b0 || evt_count !== 8'd0) begin
         failures++;
         $display("FAIL sat_rst ovf=%b count=%h exp=0/00", overflow, evt_count);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_confirm();
      test_cooldown();
      test_short_burst();
      test_overflow();
      test_sparse_valid();
      test_async_reset();
      test_saturate();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
